// File: rtl/ram_slot_seq.sv
// ram_slot_seq: 16-phase DRAM bus framer with CPU and video/refresh/DMA slot arbitration
module ram_slot_seq #(
    parameter int REF_INTERVAL = 32
) (
    input  logic       clk32,
    input  logic       porb,
    input  logic       cycsel_en,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic       vid_req,
    input  logic       dma_req,
    input  logic       dma_we,
    output logic       ras_n,
    output logic       cas_n,
    output logic       we_n,
    output logic       addr_col,
    output logic       cpu_ack,
    output logic       vid_ack,
    output logic       dma_ack,
    output logic [2:0] owner,
    output logic       locked
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CPU  = 3'd1;
    localparam logic [2:0] VID  = 3'd2;
    localparam logic [2:0] DMA  = 3'd3;
    localparam logic [2:0] REF  = 3'd4;

    logic [3:0] phase, phase_nx;
    logic [2:0] l_nx, own_sel, own_nx;
    logic [7:0] ref_cnt;
    logic       ref_pending, wr, wr_nx, lock_nx, start, vstart, expire, act, win;

    // Next-state view of the frame: outputs are registered from the phase/owner being entered,
    // so a resync (phase forced to 0) deasserts every strobe on the following clock.
    always_comb begin
        phase_nx = cycsel_en ? 4'd0 : phase + 4'd1;
        l_nx     = phase_nx[2:0];
        lock_nx  = locked | cycsel_en;
        start    = l_nx == 3'd0;
        vstart   = start && phase_nx[3] && lock_nx;
        expire   = vstart && ref_cnt == 8'(REF_INTERVAL - 1);
        own_sel  = !lock_nx ? IDLE :
                   !phase_nx[3] ? (cpu_req ? CPU : IDLE) :
                   vid_req ? VID : ref_pending ? REF : dma_req ? DMA : IDLE;
        own_nx   = start ? own_sel : owner;
        wr_nx    = start ? (own_sel == CPU ? cpu_we : (own_sel == DMA && dma_we)) : wr;
        act      = own_nx != IDLE;
        win      = act && l_nx >= 3'd1 && l_nx <= 3'd5;
    end

    // Frame state, refresh bookkeeping and registered DRAM strobes / acks.
    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            phase       <= 4'd0;
            locked      <= 1'b0;
            owner       <= IDLE;
            wr          <= 1'b0;
            ref_cnt     <= 8'd0;
            ref_pending <= 1'b0;
            ras_n       <= 1'b1;
            cas_n       <= 1'b1;
            we_n        <= 1'b1;
            addr_col    <= 1'b0;
            cpu_ack     <= 1'b0;
            vid_ack     <= 1'b0;
            dma_ack     <= 1'b0;
        end else begin
            phase       <= phase_nx;
            locked      <= lock_nx;
            owner       <= own_nx;
            wr          <= wr_nx;
            ref_cnt     <= vstart ? (expire ? 8'd0 : ref_cnt + 8'd1) : ref_cnt;
            ref_pending <= expire | (ref_pending & ~(vstart && own_sel == REF));
            ras_n       <= ~win;
            cas_n       <= ~(act && own_nx != REF && l_nx >= 3'd3 && l_nx <= 3'd5);
            we_n        <= ~(win && wr_nx);
            addr_col    <= act && l_nx >= 3'd2 && l_nx <= 3'd5;
            cpu_ack     <= l_nx == 3'd6 && own_nx == CPU;
            vid_ack     <= l_nx == 3'd6 && own_nx == VID;
            dma_ack     <= l_nx == 3'd6 && own_nx == DMA;
        end
    end
endmodule

// File: tb/tb_ram_slot_seq.sv
// tb_ram_slot_seq: randomized scenario bench for ram_slot_seq against a frame-level model
module tb_ram_slot_seq;
    localparam int R = 4;

    logic       clk32 = 0, porb = 0, cycsel_en = 0;
    logic       cpu_req = 0, cpu_we = 0, vid_req = 0, dma_req = 0, dma_we = 0;
    logic       ras_n, cas_n, we_n, addr_col, cpu_ack, vid_ack, dma_ack, locked;
    logic [2:0] owner;
    int         vectors = 0, miscompares = 0;

    int m_ph, m_own, m_vcnt;
    bit m_lock, m_wr, m_pend;

    ram_slot_seq #(.REF_INTERVAL(R)) dut (
        .clk32(clk32), .porb(porb), .cycsel_en(cycsel_en),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .vid_req(vid_req),
        .dma_req(dma_req), .dma_we(dma_we),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .addr_col(addr_col),
        .cpu_ack(cpu_ack), .vid_ack(vid_ack), .dma_ack(dma_ack),
        .owner(owner), .locked(locked)
    );

    always #5 clk32 = ~clk32;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic m_reset();
        m_ph = 0; m_own = 0; m_vcnt = 0; m_lock = 0; m_wr = 0; m_pend = 0;
    endtask

    // Frame model: slot owner chosen at each slot start, refresh due every R-th video slot.
    task automatic m_step();
        int np;
        bit nl;
        np = cycsel_en ? 0 : (m_ph + 1) % 16;
        nl = m_lock || cycsel_en;
        if (np % 8 == 0) begin
            if (!nl) m_own = 0;
            else if (np == 0) begin
                m_own = cpu_req ? 1 : 0;
                m_wr = cpu_req && cpu_we;
            end else begin
                m_vcnt++;
                m_own = vid_req ? 2 : m_pend ? 4 : dma_req ? 3 : 0;
                m_wr = (m_own == 3) && dma_we;
                if (m_own == 4) m_pend = 0;
                if (m_vcnt % R == 0) m_pend = 1;
            end
        end
        m_ph = np;
        m_lock = nl;
    endtask

    function automatic logic [10:0] expv();
        int l = m_ph % 8;
        bit a = m_own != 0;
        bit w = a && l >= 1 && l <= 5;
        return {!w, !(a && m_own != 4 && l >= 3 && l <= 5), !(w && m_wr), a && l >= 2 && l <= 5,
                l == 6 && m_own == 1, l == 6 && m_own == 2, l == 6 && m_own == 3, 3'(m_own), m_lock};
    endfunction

    function automatic logic [10:0] dutv();
        return {ras_n, cas_n, we_n, addr_col, cpu_ack, vid_ack, dma_ack, owner, locked};
    endfunction

    function automatic bit aligned();
        return m_lock && m_ph == 15;
    endfunction

    task automatic tick(input bit cs);
        cycsel_en = cs;
        @(posedge clk32);
        m_step();
        #1;
        cycsel_en = 0;
    endtask

    task automatic test_reset();
        porb = 0;
        m_reset();
        repeat (2) begin
            @(posedge clk32); #1;
            vectors++;
            if (dutv() !== expv()) begin miscompares++; $display("FAIL reset got=%b exp=%b", dutv(), expv()); end
        end
        porb = 1;
        cpu_req = 1;
        repeat (6) begin
            tick(0);
            vectors++;
            if (dutv() !== expv()) begin miscompares++; $display("FAIL prelock ph=%0d got=%b exp=%b", m_ph, dutv(), expv()); end
        end
    endtask

    task automatic test_lock_read();
        cpu_req = 1; cpu_we = 0;
        tick(1);
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("FAIL lock_set got=%b exp=1", locked); end
        repeat (32) begin
            tick(aligned());
            vectors++;
            if (dutv() !== expv()) begin miscompares++; $display("FAIL cpu_read ph=%0d got=%b exp=%b", m_ph, dutv(), expv()); end
        end
    endtask

    task automatic test_cpu_write();
        cpu_req = 1; cpu_we = 1;
        repeat (32) begin
            tick(aligned());
            vectors++;
            if (dutv() !== expv()) begin miscompares++; $display("FAIL cpu_write ph=%0d got=%b exp=%b", m_ph, dutv(), expv()); end
        end
    endtask

    task automatic test_video_priority();
        int acks = 0;
        cpu_req = 0; vid_req = 1; dma_req = 1; dma_we = 0;
        repeat (48) begin
            tick(aligned());
            acks += int'(dma_ack);
            vectors++;
            if (dutv() !== expv()) begin miscompares++; $display("FAIL vid_prio ph=%0d got=%b exp=%b", m_ph, dutv(), expv()); end
        end
        vectors++;
        if (acks != 0) begin miscompares++; $display("FAIL vid_blocks_dma got=%0d dma acks exp=0", acks); end
        vid_req = 0;
        repeat (48) begin
            tick(aligned());
            vectors++;
            if (dutv() !== expv()) begin miscompares++; $display("FAIL dma_after_vid ph=%0d got=%b exp=%b", m_ph, dutv(), expv()); end
        end
    endtask

    task automatic test_refresh();
        vid_req = 0; dma_req = 1;
        repeat (16 * 12) begin
            dma_we = 1'($urandom);
            tick(aligned());
            vectors++;
            if (dutv() !== expv()) begin miscompares++; $display("FAIL refresh ph=%0d got=%b exp=%b", m_ph, dutv(), expv()); end
        end
    endtask

    task automatic test_resync();
        bit done = 0;
        int n = 0;
        dma_req = 1; dma_we = 1'($urandom); vid_req = 0;
        while (!done && n < 200) begin
            if (m_lock && m_ph == 11 && m_own == 3) begin
                tick(1);
                done = 1;
                vectors++;
                if (ras_n !== 1'b1 || cas_n !== 1'b1 || addr_col !== 1'b0)
                    begin miscompares++; $display("FAIL resync_abort got=%b exp=110", {ras_n, cas_n, addr_col}); end
            end else tick(aligned());
            n++;
        end
        vectors++;
        if (!done) begin miscompares++; $display("FAIL resync_reach got=no_dma_at_11 exp=dma_at_11"); end
        repeat (40) begin
            tick(aligned());
            vectors++;
            if (dutv() !== expv()) begin miscompares++; $display("FAIL resync ph=%0d got=%b exp=%b", m_ph, dutv(), expv()); end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        dma_req = 0; cpu_req = 1; cpu_we = 1'($urandom);
        while (!(m_ph == 4 && m_own == 1) && n < 64) begin
            tick(aligned());
            n++;
        end
        vectors++;
        if (n >= 64) begin miscompares++; $display("FAIL reset_mid_reach got=no_cpu_phase4 exp=cpu_phase4"); end
        porb = 0;
        m_reset();
        #1;
        vectors++;
        if (dutv() !== expv()) begin miscompares++; $display("FAIL reset_async got=%b exp=%b", dutv(), expv()); end
        @(posedge clk32); #1;
        porb = 1;
        repeat (16) begin
            tick(0);
            vectors++;
            if (dutv() !== expv()) begin miscompares++; $display("FAIL reset_noack ph=%0d got=%b exp=%b", m_ph, dutv(), expv()); end
        end
        tick(1);
    endtask

    task automatic test_random();
        repeat (700) begin
            cpu_req = 1'($urandom); cpu_we = 1'($urandom);
            vid_req = ($urandom_range(0, 3) == 0); dma_req = 1'($urandom); dma_we = 1'($urandom);
            tick(aligned() || (m_lock && $urandom_range(0, 59) == 0));
            vectors++;
            if (dutv() !== expv()) begin miscompares++; $display("FAIL random ph=%0d got=%b exp=%b", m_ph, dutv(), expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_lock_read();
        test_cpu_write();
        test_video_priority();
        test_refresh();
        test_resync();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
